// File: rtl/instr_sequencer.sv
// instr_sequencer: decodes RV32I words into core fields and issues one
// instruction or a bubble per HOLD_CYCLES-clock slot through a 1-entry buffer.
module instr_sequencer #(
    parameter int HOLD_CYCLES = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic [6:0]           opcode,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [11:0]          imm12,
    output logic                 issue,
    output logic                 illegal,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int SW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(HOLD_CYCLES - 1);

    localparam logic [6:0] OP_ADD  = 7'd1;
    localparam logic [6:0] OP_SUB  = 7'd2;
    localparam logic [6:0] OP_SLT  = 7'd3;
    localparam logic [6:0] OP_ADDI = 7'd11;
    localparam logic [6:0] OP_SLTI = 7'd13;

    localparam logic [6:0] RV_OP     = 7'b0110011;
    localparam logic [6:0] RV_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } fields_t;

    localparam fields_t BUBBLE = '{
        op:  OP_ADDI,
        rd:  5'd0,
        rs1: 5'd0,
        rs2: 5'd0,
        imm: 12'd0
    };

    logic [SW-1:0]        cnt_q, cnt_d;
    logic                 buf_vld_q, buf_vld_d;
    fields_t              buf_q, buf_d;
    fields_t              out_q, out_d;
    logic                 issue_q, issue_d;
    logic                 ill_q, ill_d;
    logic [CNT_WIDTH-1:0] ret_q, ret_d;

    logic    slot_end;
    logic    accept;
    logic    consume;
    logic    dec_legal;
    fields_t dec_f;

    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        dec_f     = BUBBLE;
        dec_legal = 1'b0;
        dec_f.rd  = instr[11:7];
        dec_f.rs1 = instr[19:15];
        unique case (instr[6:0])
            RV_OP: begin
                dec_f.rs2 = instr[24:20];
                if (f3 == 3'b000 && f7 == 7'b0000000) begin
                    dec_f.op  = OP_ADD;
                    dec_legal = 1'b1;
                end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
                    dec_f.op  = OP_SUB;
                    dec_legal = 1'b1;
                end else if (f3 == 3'b010 && f7 == 7'b0000000) begin
                    dec_f.op  = OP_SLT;
                    dec_legal = 1'b1;
                end
            end
            RV_OP_IMM: begin
                dec_f.imm = instr[31:20];
                if (f3 == 3'b000) begin
                    dec_f.op  = OP_ADDI;
                    dec_legal = 1'b1;
                end else if (f3 == 3'b010) begin
                    dec_f.op  = OP_SLTI;
                    dec_legal = 1'b1;
                end
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Buffer can take a new word in the same cycle it hands its entry over
    assign slot_end    = (cnt_q == SLOT_LAST);
    assign instr_ready = reset & (~buf_vld_q | (slot_end & run));
    assign accept      = instr_valid & instr_ready;
    assign consume     = slot_end & run & buf_vld_q;

    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + SW'(1);
        buf_vld_d = buf_vld_q;
        buf_d     = buf_q;
        out_d     = out_q;
        issue_d   = 1'b0;
        ret_d     = ret_q;
        ill_d     = accept & ~dec_legal;
        if (consume) begin
            buf_vld_d = 1'b0;
        end
        if (accept && dec_legal) begin
            buf_vld_d = 1'b1;
            buf_d     = dec_f;
        end
        if (slot_end) begin
            if (consume) begin
                out_d   = buf_q;
                issue_d = 1'b1;
                ret_d   = ret_q + CNT_WIDTH'(1);
            end else begin
                out_d   = BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            buf_vld_q <= 1'b0;
            buf_q     <= BUBBLE;
            out_q     <= BUBBLE;
            issue_q   <= 1'b0;
            ill_q     <= 1'b0;
            ret_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            buf_vld_q <= buf_vld_d;
            buf_q     <= buf_d;
            out_q     <= out_d;
            issue_q   <= issue_d;
            ill_q     <= ill_d;
            ret_q     <= ret_d;
        end
    end

    assign opcode  = out_q.op;
    assign rd      = out_q.rd;
    assign rs1     = out_q.rs1;
    assign rs2     = out_q.rs2;
    assign imm12   = out_q.imm;
    assign issue   = issue_q;
    assign illegal = ill_q;
    assign busy    = buf_vld_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed vector table plus hand-written slot-timing
// sequences for instr_sequencer.
module tb_instr_sequencer;

    localparam int H  = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [11:0]   imm12;
    logic          issue;
    logic          illegal;
    logic          busy;
    logic [CW-1:0] retired;

    int tests    = 0;
    int failures = 0;
    int exp_ret  = 0;
    int tb_cnt   = 0;

    instr_sequencer #(
        .HOLD_CYCLES(H),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm12      (imm12),
        .issue      (issue),
        .illegal    (illegal),
        .busy       (busy),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Slot phase model: equals the sequencer's slot count at each negedge
    always @(posedge clk) begin
        if (!reset) tb_cnt <= 0;
        else tb_cnt <= (tb_cnt == H - 1) ? 0 : tb_cnt + 1;
    end

    typedef struct {
        string       name;
        logic [31:0] w;
        bit          legal;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
    } vec_t;

    vec_t v[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] w);
        bit done;
        done        = 1'b0;
        instr       = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 4 * H && !done; i++) begin
            if (instr_ready) done = 1'b1;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk({"accept ", name}, 32'(done), 32'd1);
    endtask

    task automatic wait_issue(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * H + 2 && !seen; i++) begin
            @(negedge clk);
            if (issue) seen = 1'b1;
        end
        chk({"issue ", name}, 32'(seen), 32'd1);
    endtask

    task automatic chk_fields(input vec_t e);
        chk({"opcode ", e.name}, 32'(opcode), 32'(e.op));
        chk({"rd ", e.name},     32'(rd),     32'(e.rd));
        chk({"rs1 ", e.name},    32'(rs1),    32'(e.rs1));
        chk({"rs2 ", e.name},    32'(rs2),    32'(e.rs2));
        chk({"imm12 ", e.name},  32'(imm12),  32'(e.imm));
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < H && tb_cnt != phase; i++) @(negedge clk);
    endtask

    initial begin
        bit   ok;
        vec_t sub_v;
        vec_t slti_v;

        v[0] = '{"ADD",  32'h002081B3, 1, 7'd1,  5'd3, 5'd1, 5'd2, 12'h000};
        v[1] = '{"ADDI", 32'h7FF00293, 1, 7'd11, 5'd5, 5'd0, 5'd0, 12'h7FF};
        v[2] = '{"SLT",  32'h0020A1B3, 1, 7'd3,  5'd3, 5'd1, 5'd2, 12'h000};
        v[3] = '{"ZERO", 32'h00000000, 0, 7'd0,  5'd0, 5'd0, 5'd0, 12'h000};
        v[4] = '{"MUL",  32'h02208033, 0, 7'd0,  5'd0, 5'd0, 5'd0, 12'h000};
        v[5] = '{"SUB",  32'h40120233, 1, 7'd2,  5'd4, 5'd4, 5'd1, 12'h000};
        v[6] = '{"SLTI", 32'hFFF12313, 1, 7'd13, 5'd6, 5'd2, 5'd0, 12'hFFF};
        v[7] = '{"SLLI", 32'h00109093, 0, 7'd0,  5'd0, 5'd0, 5'd0, 12'h000};
        v[8] = '{"BADF7",32'h4020A1B3, 0, 7'd0,  5'd0, 5'd0, 5'd0, 12'h000};
        sub_v  = v[5];
        slti_v = v[6];

        reset       = 1'b0;
        run         = 1'b1;
        instr       = 32'h002081B3;
        instr_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst ready",   32'(instr_ready), 32'd0);
        chk("rst opcode",  32'(opcode),      32'd11);
        chk("rst rd",      32'(rd),          32'd0);
        chk("rst retired", 32'(retired),     32'd0);
        chk("rst busy",    32'(busy),        32'd0);
        chk("rst issue",   32'(issue),       32'd0);
        instr_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 9; n++) begin
            push(v[n].name, v[n].w);
            chk({"illegal ", v[n].name}, 32'(illegal), 32'(!v[n].legal));
            chk({"busy ", v[n].name},    32'(busy),    32'(v[n].legal));
            if (v[n].legal) begin
                wait_issue(v[n].name);
                exp_ret++;
                chk_fields(v[n]);
                chk({"retired ", v[n].name}, 32'(retired), 32'(exp_ret));
                ok = 1'b1;
                for (int k = 1; k < H; k++) begin
                    @(negedge clk);
                    if (issue || opcode !== v[n].op || rd !== v[n].rd) ok = 1'b0;
                end
                chk({"hold ", v[n].name}, 32'(ok), 32'd1);
                @(negedge clk);
                chk({"bubble op ", v[n].name}, 32'(opcode), 32'd11);
                chk({"bubble rd ", v[n].name}, 32'(rd),     32'd0);
            end else begin
                ok = 1'b1;
                for (int k = 0; k < 2 * H; k++) begin
                    @(negedge clk);
                    if (issue || opcode !== 7'd11 || busy) ok = 1'b0;
                end
                chk({"no issue ", v[n].name}, 32'(ok), 32'd1);
                chk({"retired ", v[n].name}, 32'(retired), 32'(exp_ret));
            end
        end

        // Back-to-back: second word stalls until the slot boundary
        align(0);
        push("b2b SUB", sub_v.w);
        instr       = slti_v.w;
        instr_valid = 1'b1;
        chk("b2b stall ready", 32'(instr_ready), 32'd0);
        push("b2b SLTI", slti_v.w);
        exp_ret++;
        chk("b2b sub issue", 32'(issue), 32'd1);
        chk_fields(sub_v);
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b retired1", 32'(retired), 32'(exp_ret));
        wait_issue("b2b SLTI");
        exp_ret++;
        chk_fields(slti_v);
        chk("b2b retired2", 32'(retired), 32'(exp_ret));

        // Illegal word at slot_end while the buffer is full
        align(0);
        push("full ADD", v[0].w);
        push("full ZERO", 32'h00000000);
        exp_ret++;
        chk("full issue",   32'(issue),   32'd1);
        chk("full illegal", 32'(illegal), 32'd1);
        chk("full opcode",  32'(opcode),  32'd1);
        chk("full busy",    32'(busy),    32'd0);
        chk("full retired", 32'(retired), 32'(exp_ret));

        // run=0 holds the entry; reset mid-slot discards it
        repeat (H) @(negedge clk);
        align(0);
        run = 1'b0;
        push("hold ADD", v[0].w);
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!busy || issue || instr_ready || opcode !== 7'd11) ok = 1'b0;
        end
        chk("run0 bubbles", 32'(ok), 32'd1);
        align(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst busy",    32'(busy),        32'd0);
        chk("midrst retired", 32'(retired),     32'd0);
        chk("midrst opcode",  32'(opcode),      32'd11);
        chk("midrst ready",   32'(instr_ready), 32'd0);
        reset   = 1'b1;
        run     = 1'b1;
        exp_ret = 0;
        ok      = 1'b1;
        for (int k = 0; k < 3 * H; k++) begin
            @(negedge clk);
            if (issue || busy) ok = 1'b0;
        end
        chk("midrst no issue", 32'(ok), 32'd1);
        chk("midrst retired2", 32'(retired), 32'(exp_ret));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
